// File: rtl/pixel_frame_sequencer.sv
// Frame-timing controller for the pixel array: ERASE, EXPOSE, CONVERT, READ sequencing with
// runtime exposure, START handshake, single-shot/continuous frames and synchronous ABORT.
module pixel_frame_sequencer #(
    parameter int unsigned ROWS            = 2,
    parameter int unsigned PIXEL_BITS      = 8,
    parameter int unsigned ERASE_CYCLES    = 5,
    parameter int unsigned ROW_READ_CYCLES = 5,
    parameter int unsigned EXPOSE_BITS     = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   CONTINUOUS,
    input  logic                   ABORT,
    input  logic [EXPOSE_BITS-1:0] EXPOSE_TIME,
    output logic                   PIXEL_ERASE,
    output logic                   PIXEL_EXPOSE,
    output logic                   PIXEL_CONVERT,
    output logic [PIXEL_BITS-1:0]  PIXEL_CONVERT_COUNTER,
    output logic [ROWS-1:0]        SENSOR_ROW_SELECT,
    output logic                   NEW_ROW,
    output logic                   BUSY,
    output logic                   FRAME_FINISHED
);

    localparam int unsigned CONV_LEN = 2 ** PIXEL_BITS;
    localparam int unsigned EXP_MAX  = (2 ** EXPOSE_BITS) - 1;
    localparam int unsigned MAX_A    = (ERASE_CYCLES > ROW_READ_CYCLES) ? ERASE_CYCLES
                                                                        : ROW_READ_CYCLES;
    localparam int unsigned MAX_B    = (CONV_LEN > EXP_MAX) ? CONV_LEN : EXP_MAX;
    localparam int unsigned MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // Counter holds phase index 0..len-1; one extra value of headroom keeps the width safe.
    localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);
    localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_LEN - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_READ_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StExpose,
        StConvert,
        StRead
    } state_t;

    state_t                 r_state, w_state_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic [ROW_W-1:0]       r_row, w_row_d;
    logic [EXPOSE_BITS-1:0] r_expose, w_expose_d;
    logic                   w_finish_d;
    logic [CNT_W-1:0]       w_expose_last;

    logic                   r_erase;
    logic                   r_expose_out;
    logic                   r_convert;
    logic [PIXEL_BITS-1:0]  r_conv_cnt;
    logic [ROWS-1:0]        r_row_sel;
    logic                   r_new_row;
    logic                   r_busy;
    logic                   r_finished;

    // Exposure of 0 behaves as 1 cycle, so the last index is 0 in both cases.
    assign w_expose_last = (r_expose == '0) ? '0 : CNT_W'(r_expose) - CNT_W'(1);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt + CNT_W'(1);
        w_row_d    = r_row;
        w_expose_d = r_expose;
        w_finish_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                w_row_d = '0;
                if (START) begin
                    w_state_d  = StErase;
                    w_expose_d = EXPOSE_TIME;
                end
            end
            StErase: begin
                if (r_cnt == ERASE_LAST) begin
                    w_state_d = StExpose;
                    w_cnt_d   = '0;
                end
            end
            StExpose: begin
                if (r_cnt == w_expose_last) begin
                    w_state_d = StConvert;
                    w_cnt_d   = '0;
                end
            end
            StConvert: begin
                if (r_cnt == CONV_LAST) begin
                    w_state_d = StRead;
                    w_cnt_d   = '0;
                    w_row_d   = '0;
                end
            end
            StRead: begin
                if (r_cnt == ROW_LAST) begin
                    w_cnt_d = '0;
                    if (r_row == LAST_ROW) begin
                        w_finish_d = 1'b1;
                        w_row_d    = '0;
                        if (CONTINUOUS) begin
                            w_state_d  = StErase;
                            w_expose_d = EXPOSE_TIME;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_row_d = r_row + ROW_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_row_d   = '0;
            end
        endcase
        // Abort wins over START and over the end-of-frame transition.
        if (ABORT) begin
            w_state_d  = StIdle;
            w_cnt_d    = '0;
            w_row_d    = '0;
            w_expose_d = r_expose;
            w_finish_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_row    <= '0;
            r_expose <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_row    <= w_row_d;
            r_expose <= w_expose_d;
        end
    end

    // Outputs are registered from the next-state values so they line up with r_state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_erase      <= 1'b0;
            r_expose_out <= 1'b0;
            r_convert    <= 1'b0;
            r_conv_cnt   <= '0;
            r_row_sel    <= '0;
            r_new_row    <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
        end else begin
            r_erase      <= (w_state_d == StErase);
            r_expose_out <= (w_state_d == StExpose);
            r_convert    <= (w_state_d == StConvert);
            r_conv_cnt   <= (w_state_d == StConvert) ? w_cnt_d[PIXEL_BITS-1:0] : '0;
            r_row_sel    <= (w_state_d == StRead) ? (ROWS'(1) << w_row_d) : '0;
            r_new_row    <= (w_state_d == StRead) && (w_cnt_d == '0);
            r_busy       <= (w_state_d != StIdle);
            r_finished   <= w_finish_d;
        end
    end

    assign PIXEL_ERASE           = r_erase;
    assign PIXEL_EXPOSE          = r_expose_out;
    assign PIXEL_CONVERT         = r_convert;
    assign PIXEL_CONVERT_COUNTER = r_conv_cnt;
    assign SENSOR_ROW_SELECT     = r_row_sel;
    assign NEW_ROW               = r_new_row;
    assign BUSY                  = r_busy;
    assign FRAME_FINISHED        = r_finished;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer (ROWS=4, PIXEL_BITS=4, ERASE=3, ROW_READ=2, EXPOSE_BITS=6).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_pixel_frame_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       CONTINUOUS = 1'b0;
    logic       ABORT = 1'b0;
    logic [5:0] EXPOSE_TIME = '0;
    logic       PIXEL_ERASE, PIXEL_EXPOSE, PIXEL_CONVERT, NEW_ROW, BUSY, FRAME_FINISHED;
    logic [3:0] PIXEL_CONVERT_COUNTER;
    logic [3:0] SENSOR_ROW_SELECT;
    logic [13:0] w_obs;

    int checks = 0;
    int errors = 0;

    pixel_frame_sequencer #(
        .ROWS            (4),
        .PIXEL_BITS      (4),
        .ERASE_CYCLES    (3),
        .ROW_READ_CYCLES (2),
        .EXPOSE_BITS     (6)
    ) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .START                 (START),
        .CONTINUOUS            (CONTINUOUS),
        .ABORT                 (ABORT),
        .EXPOSE_TIME           (EXPOSE_TIME),
        .PIXEL_ERASE           (PIXEL_ERASE),
        .PIXEL_EXPOSE          (PIXEL_EXPOSE),
        .PIXEL_CONVERT         (PIXEL_CONVERT),
        .PIXEL_CONVERT_COUNTER (PIXEL_CONVERT_COUNTER),
        .SENSOR_ROW_SELECT     (SENSOR_ROW_SELECT),
        .NEW_ROW               (NEW_ROW),
        .BUSY                  (BUSY),
        .FRAME_FINISHED        (FRAME_FINISHED)
    );

    always #5 CLK = ~CLK;

    assign w_obs = {PIXEL_ERASE, PIXEL_EXPOSE, PIXEL_CONVERT, PIXEL_CONVERT_COUNTER,
                    SENSOR_ROW_SELECT, NEW_ROW, BUSY, FRAME_FINISHED};

    // Expected output vector for cycle i of a frame (0 = first ERASE cycle), FRAME_FINISHED clear.
    function automatic logic [13:0] exp_out(input int i, input int e);
        int ee;
        int j;
        logic [13:0] v;
        ee = (e == 0) ? 1 : e;
        v  = '0;
        if (i < 3) begin
            v[13] = 1'b1;
        end else if (i < 3 + ee) begin
            v[12] = 1'b1;
        end else if (i < 3 + ee + 16) begin
            v[11]   = 1'b1;
            v[10:7] = 4'(i - 3 - ee);
        end else begin
            j      = i - 3 - ee - 16;
            v[6:3] = 4'(1 << (j / 2));
            v[2]   = ((j % 2) == 0);
        end
        v[1] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (w_obs !== 14'b0) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", w_obs, 14'b0);
        end
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (w_obs !== 14'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b want %b", i, w_obs, 14'b0);
            end
        end
    endtask

    task automatic test_single_frame();
        int nr = 0;
        int bz = 0;
        EXPOSE_TIME = 6'd7;
        CONTINUOUS  = 1'b0;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (w_obs !== exp_out(i, 7)) begin
                errors++;
                $display("FAIL single_frame cycle %0d: got %b want %b", i, w_obs, exp_out(i, 7));
            end
            nr += int'(NEW_ROW);
            bz += int'(BUSY);
            tick();
        end
        checks++;
        if (w_obs !== 14'b1) begin
            errors++;
            $display("FAIL single_finished: got %b want %b", w_obs, 14'b1);
        end
        tick();
        checks++;
        if (w_obs !== 14'b0) begin
            errors++;
            $display("FAIL single_idle_after: got %b want %b", w_obs, 14'b0);
        end
        checks++;
        if (nr !== 4) begin
            errors++;
            $display("FAIL single_new_row_count: got %0d want 4", nr);
        end
        checks++;
        if (bz !== 34) begin
            errors++;
            $display("FAIL single_busy_count: got %0d want 34", bz);
        end
    endtask

    task automatic test_continuous();
        logic [13:0] want;
        EXPOSE_TIME = 6'd7;
        CONTINUOUS  = 1'b1;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (w_obs !== exp_out(i, 7)) begin
                errors++;
                $display("FAIL cont_frame1 cycle %0d: got %b want %b", i, w_obs, exp_out(i, 7));
            end
            if (i == 14) EXPOSE_TIME = 6'd2;
            tick();
        end
        for (int i = 0; i < 29; i++) begin
            want = exp_out(i, 2) | ((i == 0) ? 14'b1 : 14'b0);
            checks++;
            if (w_obs !== want) begin
                errors++;
                $display("FAIL cont_frame2 cycle %0d: got %b want %b", i, w_obs, want);
            end
            if (i == 5) CONTINUOUS = 1'b0;
            tick();
        end
        checks++;
        if (w_obs !== 14'b1) begin
            errors++;
            $display("FAIL cont_finished: got %b want %b", w_obs, 14'b1);
        end
        tick();
        checks++;
        if (w_obs !== 14'b0) begin
            errors++;
            $display("FAIL cont_idle_after: got %b want %b", w_obs, 14'b0);
        end
    endtask

    task automatic test_zero_expose();
        int ex = 0;
        EXPOSE_TIME = 6'd0;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 28; i++) begin
            checks++;
            if (w_obs !== exp_out(i, 0)) begin
                errors++;
                $display("FAIL zero_expose cycle %0d: got %b want %b", i, w_obs, exp_out(i, 0));
            end
            ex += int'(PIXEL_EXPOSE);
            tick();
        end
        checks++;
        if (w_obs !== 14'b1) begin
            errors++;
            $display("FAIL zero_finished: got %b want %b", w_obs, 14'b1);
        end
        checks++;
        if (ex !== 1) begin
            errors++;
            $display("FAIL zero_expose_len: got %0d want 1", ex);
        end
        tick();
    endtask

    task automatic test_abort();
        EXPOSE_TIME = 6'd3;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (w_obs !== exp_out(i, 3)) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %b want %b", i, w_obs, exp_out(i, 3));
            end
            if (i == 11) ABORT = 1'b1;
            else tick();
        end
        tick();
        ABORT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (w_obs !== 14'b0) begin
                errors++;
                $display("FAIL abort_idle cycle %0d: got %b want %b", i, w_obs, 14'b0);
            end
            tick();
        end
        EXPOSE_TIME = 6'd1;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 28; i++) begin
            checks++;
            if (w_obs !== exp_out(i, 1)) begin
                errors++;
                $display("FAIL abort_rerun cycle %0d: got %b want %b", i, w_obs, exp_out(i, 1));
            end
            tick();
        end
        checks++;
        if (w_obs !== 14'b1) begin
            errors++;
            $display("FAIL abort_rerun_finished: got %b want %b", w_obs, 14'b1);
        end
        tick();
    endtask

    task automatic test_async_reset();
        EXPOSE_TIME = 6'd1;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        checks++;
        if (w_obs !== exp_out(22, 1)) begin
            errors++;
            $display("FAIL areset_pre: got %b want %b", w_obs, exp_out(22, 1));
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (w_obs !== 14'b0) begin
            errors++;
            $display("FAIL areset_immediate: got %b want %b", w_obs, 14'b0);
        end
        tick();
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (w_obs !== 14'b0) begin
                errors++;
                $display("FAIL areset_idle cycle %0d: got %b want %b", i, w_obs, 14'b0);
            end
        end
        EXPOSE_TIME = 6'd4;
        START       = 1'b1;
        tick();
        START = 1'b0;
        checks++;
        if (w_obs !== exp_out(0, 4)) begin
            errors++;
            $display("FAIL areset_restart: got %b want %b", w_obs, exp_out(0, 4));
        end
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
    endtask

    task automatic test_handshake();
        EXPOSE_TIME = 6'd5;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (w_obs !== exp_out(i, 5)) begin
                errors++;
                $display("FAIL start_in_expose cycle %0d: got %b want %b", i, w_obs, exp_out(i, 5));
            end
            START = (i == 4);
            tick();
        end
        START = 1'b0;
        checks++;
        if (w_obs !== 14'b1) begin
            errors++;
            $display("FAIL start_in_expose_finished: got %b want %b", w_obs, 14'b1);
        end
        tick();
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (w_obs !== 14'b0) begin
                errors++;
                $display("FAIL start_abort_idle cycle %0d: got %b want %b", i, w_obs, 14'b0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_zero_expose();
        test_abort();
        test_async_reset();
        test_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_frame_sequencer.md
Name: pixel_frame_sequencer

Overview:
Parametrised frame-timing controller for the pixel sensor array. It sequences ERASE, EXPOSE, CONVERT and READ phases over an N-row array and generates the digital ramp count and one-hot row select. New in this generation: exposure time is programmable at runtime, frames start on a START handshake, frames can run single-shot or continuous, and an ABORT input cancels a frame. It sits between the top-level sensor control and the pixel array/readout path.

Parameters:
ROWS, 2, number of pixel rows; width of SENSOR_ROW_SELECT; must be >= 1
PIXEL_BITS, 8, ramp/counter width; CONVERT phase lasts 2**PIXEL_BITS cycles
ERASE_CYCLES, 5, ERASE phase length in cycles; must be >= 1
ROW_READ_CYCLES, 5, cycles each row stays selected; must be >= 1
EXPOSE_BITS, 10, width of EXPOSE_TIME

Ports:
CLK  input  1  clock; all logic rising-edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request a frame; sampled only in IDLE
CONTINUOUS  input  1  1 = start the next frame immediately after READ
ABORT  input  1  synchronous cancel of the current frame
EXPOSE_TIME  input  EXPOSE_BITS  exposure length in cycles; 0 is treated as 1
PIXEL_ERASE  output  1  high during ERASE
PIXEL_EXPOSE  output  1  high during EXPOSE
PIXEL_CONVERT  output  1  high during CONVERT; ramp-enable level, not a gated clock
PIXEL_CONVERT_COUNTER  output  PIXEL_BITS  digital ramp value
SENSOR_ROW_SELECT  output  ROWS  one-hot row select during READ, else 0
NEW_ROW  output  1  one-cycle pulse on the first cycle of each selected row
BUSY  output  1  high in every state except IDLE
FRAME_FINISHED  output  1  one-cycle pulse after a frame completes normally

Behaviour:
- Reset: RESET is asynchronous and active-high; clock is CLK. While RESET is high, or after it is released, the block is in IDLE with every output at 0. The internal phase counter, row index and latched exposure are cleared.
- All outputs are registered and decoded from the state registers. There are no combinational paths from inputs to outputs.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE to ERASE: START=1 and ABORT=0 at edge k puts ERASE on the outputs from cycle k+1. EXPOSE_TIME is latched at that same edge. START in any non-IDLE state is ignored.
- ERASE: PIXEL_ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: PIXEL_EXPOSE=1 for exactly max(latched EXPOSE_TIME, 1) cycles, then CONVERT. Changes to EXPOSE_TIME mid-frame have no effect on the current frame.
- CONVERT: PIXEL_CONVERT=1 for 2**PIXEL_BITS cycles. The counter is 0 on the first cycle and increments by 1 each cycle, reaching all-ones on the last cycle. It does not wrap within the phase. It is 0 in every other state.
- READ: lasts ROWS*ROW_READ_CYCLES cycles. Row r (bit r) is selected for cycles r*ROW_READ_CYCLES through (r+1)*ROW_READ_CYCLES-1 of READ, starting at r=0. Exactly one bit is high throughout READ. NEW_ROW=1 on the first cycle of each row, giving ROWS pulses per frame.
- End of READ: the next state is decided by CONTINUOUS sampled at the edge ending the last READ cycle.
  - CONTINUOUS=1: go to ERASE with no gap and re-latch EXPOSE_TIME.
  - CONTINUOUS=0: go to IDLE.
  - In both cases FRAME_FINISHED=1 for that following single cycle.
- ABORT=1 at any edge in a non-IDLE state forces IDLE on the next cycle. All outputs go to 0 and no FRAME_FINISHED is generated. ABORT has priority over START and over the end-of-READ transition.
- Frame length in BUSY cycles: ERASE_CYCLES + max(E,1) + 2**PIXEL_BITS + ROWS*ROW_READ_CYCLES.
- Phase counter width must cover the largest phase length with no overflow.
- RESET mid-frame clears outputs immediately, without waiting for a clock edge.

Test Plan:
(Parameters: ROWS=4, PIXEL_BITS=4, ERASE_CYCLES=3, ROW_READ_CYCLES=2, EXPOSE_BITS=6.)
- Single frame: EXPOSE_TIME=7, one-cycle START, CONTINUOUS=0 -> 3 cycles ERASE, then 7 EXPOSE, then 16 CONVERT with counter 0..15, then 8 READ with row select 0001,0010,0100,1000 for 2 cycles each. Expect 4 NEW_ROW pulses, BUSY high for 34 cycles, one FRAME_FINISHED pulse, then IDLE.
- Continuous: CONTINUOUS=1 with EXPOSE_TIME=7; change EXPOSE_TIME to 2 during CONVERT -> frame 2 starts ERASE the cycle after READ ends, with no idle gap and a FRAME_FINISHED pulse. Frame 2 EXPOSE lasts 2 cycles (BUSY 29 cycles); frame 1 EXPOSE stayed at 7.
- Zero exposure: EXPOSE_TIME=0 -> PIXEL_EXPOSE high for exactly 1 cycle; frame total 28 cycles.
- Abort: ABORT pulse during CONVERT while counter=5 -> next cycle IDLE, all outputs 0, no FRAME_FINISHED. A later START runs a full correct frame.
- Async reset: RESET asserted mid-READ between clock edges -> outputs 0 immediately. After release, IDLE until START.
- Handshake corners: START during EXPOSE -> ignored, frame timing unchanged. START and ABORT together in IDLE -> stays IDLE.
